// File: rtl/wave_sched_pkg.sv
// Shared types and widths for the wave-sample SDRAM port scheduler.
package wave_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  localparam int MEM_AW = 25;
  localparam int MEM_DW = 16;

endpackage

// File: rtl/wave_sdram_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = IW'((int'(ptr) + i) % N);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/wave_sdram_sched.sv
// Shares the sound-sample SDRAM port between the ROM download writer and the
// wave channel readers: writes first, channels round-robin, one access in flight.
module wave_sdram_sched
  import wave_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CAW     = 20,
  parameter int TIMEOUT = 63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dl_active,
  input  logic                dl_wr,
  input  logic [MEM_AW-1:0]   dl_addr,
  input  logic [7:0]          dl_data,
  output logic                dl_busy,
  output logic                dl_ovf,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH*CAW-1:0]  ch_addr,
  output logic [NCH-1:0]      ch_ack,
  output logic [MEM_DW-1:0]   ch_data,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_we,
  output logic [7:0]          mem_din,
  input  logic [MEM_DW-1:0]   mem_dout,
  input  logic                mem_ack,
  output logic                timeout_err
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e            state_q, state_d;
  logic              buf_full_q, buf_full_d;
  logic [MEM_AW-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [5:0]        wd_cnt_q, wd_cnt_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [NCH-1:0]    ch_ack_q, ch_ack_d;
  logic [MEM_DW-1:0] ch_data_q, ch_data_d;
  logic              dl_ovf_q, dl_ovf_d;
  logic              timeout_err_q, timeout_err_d;
  logic              drain;

  logic [NCH-1:0]    arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;

  rr_arbiter #(.N(NCH), .IW(PW)) u_arb (
    .req (ch_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d       = state_q;
    buf_full_d    = buf_full_q;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    wd_cnt_d      = wd_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_din_d     = mem_din_q;
    ch_ack_d      = '0;
    ch_data_d     = ch_data_q;
    dl_ovf_d      = dl_ovf_q;
    timeout_err_d = timeout_err_q;
    drain         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          mem_we_d   = 1'b1;
          mem_addr_d = buf_addr_q;
          mem_din_d  = buf_data_q;
          wd_cnt_d   = '0;
          state_d    = S_WRITE;
        end else if (!dl_wr && !dl_active && arb_any) begin
          // A strobe arriving this cycle lands in the buffer next cycle; hold
          // the read back so the write still goes first.
          mem_rd_d   = 1'b1;
          mem_addr_d = MEM_AW'(ch_addr[int'(arb_idx)*CAW +: CAW]);
          grant_d    = arb_idx;
          wd_cnt_d   = '0;
          state_d    = S_READ;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          drain   = 1'b1;
          state_d = S_IDLE;
        end else if (wd_cnt_q == 6'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 6'd1;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          ch_data_d         = mem_dout;
          ch_ack_d[grant_q] = 1'b1;
          rr_ptr_d          = (grant_q == PW'(NCH - 1)) ? '0 : grant_q + PW'(1);
          state_d           = S_IDLE;
        end else if (wd_cnt_q == 6'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Single-entry buffer: a strobe in the draining cycle refills it.
    if (drain) begin
      buf_full_d = 1'b0;
    end
    if (dl_wr) begin
      if (!buf_full_q || drain) begin
        buf_full_d = 1'b1;
        buf_addr_d = dl_addr;
        buf_data_d = dl_data;
      end else begin
        dl_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      buf_full_q    <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      wd_cnt_q      <= '0;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_din_q     <= '0;
      ch_ack_q      <= '0;
      ch_data_q     <= '0;
      dl_ovf_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_full_q    <= buf_full_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      wd_cnt_q      <= wd_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      mem_we_q      <= mem_we_d;
      mem_din_q     <= mem_din_d;
      ch_ack_q      <= ch_ack_d;
      ch_data_q     <= ch_data_d;
      dl_ovf_q      <= dl_ovf_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign dl_busy     = buf_full_q;
  assign dl_ovf      = dl_ovf_q;
  assign ch_ack      = ch_ack_q;
  assign ch_data     = ch_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_we      = mem_we_q;
  assign mem_din     = mem_din_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wave_sdram_sched.sv
// Scoreboard bench for wave_sdram_sched with a latency-programmable memory responder.
module tb_wave_sdram_sched;

  localparam int NCH     = 4;
  localparam int CAW     = 20;
  localparam int TIMEOUT = 63;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
  } wr_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               dl_active;
  logic               dl_wr;
  logic [24:0]        dl_addr;
  logic [7:0]         dl_data;
  logic               dl_busy;
  logic               dl_ovf;
  logic [NCH-1:0]     ch_req;
  logic [NCH*CAW-1:0] ch_addr;
  logic [NCH-1:0]     ch_ack;
  logic [15:0]        ch_data;
  logic [24:0]        mem_addr;
  logic               mem_rd;
  logic               mem_we;
  logic [7:0]         mem_din;
  logic [15:0]        mem_dout;
  logic               mem_ack;
  logic               timeout_err;

  always #5 clk = ~clk;

  wave_sdram_sched #(.NCH(NCH), .CAW(CAW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy), .dl_ovf(dl_ovf),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack), .ch_data(ch_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int ack_cnt = 0;

  logic [CAW-1:0] ca [NCH];
  wr_t exp_wr [$];
  int  exp_ch [$];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_word(logic [24:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // Memory responder: acks ack_lat cycles after a strobe, read data derived from address.
  int          ack_lat = 3;
  bit          ack_en  = 1'b1;
  int          pend    = 0;
  logic [24:0] pend_addr;
  bit          pend_rd;

  initial begin
    mem_ack  = 1'b0;
    mem_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_ack  = 1'b1;
          mem_dout = pend_rd ? rd_word(pend_addr) : 16'h0;
        end
      end else if ((mem_rd || mem_we) && ack_en && !reset) begin
        pend      = ack_lat;
        pend_addr = mem_addr;
        pend_rd   = mem_rd;
      end
    end
  end

  wr_t w;
  int  c;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        we_cnt++;
        if (exp_wr.size() == 0) check_eq("we_unexpected", exp_wr.size(), 1);
        else begin
          w = exp_wr.pop_front();
          check_eq("we_addr", mem_addr, w.a);
          check_eq("we_din", mem_din, w.d);
        end
      end
      if (mem_rd) begin
        rd_cnt++;
        if (exp_ch.size() == 0) check_eq("rd_unexpected", exp_ch.size(), 1);
        else check_eq("rd_addr", mem_addr, {5'b0, ca[exp_ch[0]]});
      end
      if (ch_ack != '0) begin
        ack_cnt++;
        if (exp_ch.size() == 0) check_eq("ack_unexpected", exp_ch.size(), 1);
        else begin
          c = exp_ch.pop_front();
          check_eq("ack_onehot", ch_ack, 32'(1) << c);
          check_eq("ch_data", ch_data, rd_word({5'b0, ca[c]}));
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dl_write(logic [24:0] a, logic [7:0] d, bit push);
    wr_t e;
    @(posedge clk);
    #1;
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    if (push) begin
      e.a = a;
      e.d = d;
      exp_wr.push_back(e);
    end
    @(posedge clk);
    #1;
    dl_wr = 1'b0;
  endtask

  task automatic wait_acks(string tag, int target, int budget);
    int n = 0;
    for (int i = 0; i < budget && n < target; i++) begin
      @(posedge clk);
      #1;
      if (|ch_ack) n++;
    end
    check_eq(tag, n, target);
  endtask

  initial begin
    int base;
    int n;
    int acks;
    bit seen_rd, we_first, wack_first, found;

    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    ch_req    = '0;
    for (int i = 0; i < NCH; i++) begin
      ca[i] = CAW'(20'h12340 + i * 20'h01111);
      ch_addr[i*CAW +: CAW] = ca[i];
    end
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", dl_busy, 0);
    check_eq("rst_ovf", dl_ovf, 0);
    check_eq("rst_ack", ch_ack, 0);
    check_eq("rst_data", ch_data, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_strobes", {mem_rd, mem_we}, 0);
    check_eq("rst_din", mem_din, 0);
    check_eq("rst_terr", timeout_err, 0);

    // Single download write, ack 5 cycles after the strobe
    ack_lat = 5;
    base = we_cnt;
    dl_write(25'h00010, 8'hA5, 1'b1);
    check_eq("t1_busy_set", dl_busy, 1);
    cycles(12);
    check_eq("t1_busy_clr", dl_busy, 0);
    check_eq("t1_we_count", we_cnt - base, 1);

    // All channels requesting: round-robin order
    ack_lat = 1;
    @(posedge clk);
    #1;
    ch_req = 4'b1111;
    exp_ch.push_back(0); exp_ch.push_back(1); exp_ch.push_back(2);
    exp_ch.push_back(3); exp_ch.push_back(0);
    wait_acks("t2_acks", 5, 200);
    ch_req = '0;
    cycles(3);

    // Write and channel request arriving together: write goes first
    @(posedge clk);
    #1;
    dl_wr = 1'b1; dl_addr = 25'h01ABCD; dl_data = 8'h3C;
    ch_req = 4'b0100;
    w.a = 25'h01ABCD; w.d = 8'h3C;
    exp_wr.push_back(w);
    exp_ch.push_back(2);
    @(posedge clk);
    #1;
    dl_wr = 1'b0;
    seen_rd = 0; we_first = 0; wack_first = 0; n = 0;
    for (int i = 0; i < 100 && n == 0; i++) begin
      if (mem_we && !seen_rd) we_first = 1;
      if (mem_ack && !seen_rd) wack_first = 1;
      if (mem_rd) seen_rd = 1;
      if (|ch_ack) n++;
      else begin @(posedge clk); #1; end
    end
    ch_req = '0;
    check_eq("t3_we_first", we_first, 1);
    check_eq("t3_wack_first", wack_first, 1);
    check_eq("t3_read_done", n, 1);
    cycles(3);

    // Second strobe while buffer full is dropped
    ack_lat = 10;
    base = we_cnt;
    dl_write(25'h00200, 8'h11, 1'b1);
    dl_write(25'h00300, 8'h22, 1'b0);
    cycles(20);
    check_eq("t4_ovf", dl_ovf, 1);
    check_eq("t4_we_count", we_cnt - base, 1);
    check_eq("t4_busy_clr", dl_busy, 0);

    // Watchdog on an unanswered read of ch1
    ack_lat = 2;
    check_eq("t5_terr_pre", timeout_err, 0);
    ack_en = 1'b0;
    base = rd_cnt;
    @(posedge clk);
    #1;
    ch_req = 4'b0010;
    exp_ch.push_back(1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mem_rd) found = 1;
    end
    check_eq("t5_rd_issued", found, 1);
    n = 0; acks = 0;
    for (int i = 0; i < 100 && !timeout_err; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (|ch_ack) acks++;
    end
    ack_en = 1'b1;
    check_eq("t5_wd_cycles", n, TIMEOUT);
    check_eq("t5_no_ack", acks, 0);
    wait_acks("t5_reissue_ack", 1, 30);
    ch_req = '0;
    check_eq("t5_rd_count", rd_cnt - base, 2);
    cycles(3);

    // Reads held off while a download is active
    @(posedge clk);
    #1;
    dl_active = 1'b1;
    ch_req = 4'b0001;
    exp_ch.push_back(0);
    base = rd_cnt;
    cycles(10);
    check_eq("t6_no_rd", rd_cnt - base, 0);
    dl_active = 1'b0;
    n = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (mem_rd) found = 1;
    end
    check_eq("t6_rd_latency_ok", found && n <= 2, 1);
    wait_acks("t6_ack", 1, 20);
    ch_req = '0;
    cycles(3);

    // Reset in the middle of a write access
    ack_en = 1'b0;
    dl_write(25'h00ABCD, 8'h5A, 1'b1);
    cycles(4);
    base = we_cnt;
    reset = 1'b1;
    cycles(2);
    check_eq("t7_busy", dl_busy, 0);
    check_eq("t7_addr", mem_addr, 0);
    check_eq("t7_ovf", dl_ovf, 0);
    check_eq("t7_terr", timeout_err, 0);
    reset = 1'b0;
    ack_en = 1'b1;
    base = ack_cnt;
    cycles(10);
    check_eq("t7_no_ack", ack_cnt - base, 0);

    check_eq("sb_wr_empty", exp_wr.size(), 0);
    check_eq("sb_ch_empty", exp_ch.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
